// File: rtl/mem_1rw_arb.sv
// Two-requester round-robin arbiter in front of a single-port (1RW) memory.
// Each requester may have one read outstanding; unconsumed read data is parked in a hold register.
module mem_1rw_arb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_wmode,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_wmode,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_rdata,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_rdata,
  output logic [ADDR_WIDTH-1:0] RW0_addr,
  output logic                  RW0_en,
  output logic                  RW0_clk,
  output logic                  RW0_wmode,
  output logic [DATA_WIDTH-1:0] RW0_wdata,
  input  logic [DATA_WIDTH-1:0] RW0_rdata
);

  typedef enum logic {LAST_REQ0 = 1'b0, LAST_REQ1 = 1'b1} last_t;

  last_t                 last_grant, last_grant_nxt;
  logic                  inflight0, inflight1;
  logic                  holdv0, holdv1;
  logic [DATA_WIDTH-1:0] hold0, hold1;
  logic                  elig0, elig1;
  logic                  grant0, grant1;

  assign RW0_clk = clock;

  always_comb begin
    elig0          = req0_valid & ~inflight0 & ~holdv0 & ~reset;
    elig1          = req1_valid & ~inflight1 & ~holdv1 & ~reset;
    grant0         = elig0 & (~elig1 | (last_grant == LAST_REQ1));
    grant1         = elig1 & (~elig0 | (last_grant == LAST_REQ0));
    last_grant_nxt = last_grant;
    if (grant0)
      last_grant_nxt = LAST_REQ0;
    else if (grant1)
      last_grant_nxt = LAST_REQ1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    RW0_en    = 1'b0;
    RW0_addr  = '0;
    RW0_wmode = 1'b0;
    RW0_wdata = '0;
    if (grant0) begin
      RW0_en    = 1'b1;
      RW0_addr  = req0_addr;
      RW0_wmode = req0_wmode;
      RW0_wdata = req0_wdata;
    end else if (grant1) begin
      RW0_en    = 1'b1;
      RW0_addr  = req1_addr;
      RW0_wmode = req1_wmode;
      RW0_wdata = req1_wdata;
    end
  end

  // Reset also masks the response in the cycle it is asserted, so an in-flight read never shows.
  assign resp0_valid = ~reset & (inflight0 | holdv0);
  assign resp1_valid = ~reset & (inflight1 | holdv1);
  assign resp0_rdata = holdv0 ? hold0 : RW0_rdata;
  assign resp1_rdata = holdv1 ? hold1 : RW0_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= LAST_REQ1;
      inflight0  <= 1'b0;
      inflight1  <= 1'b0;
      holdv0     <= 1'b0;
      holdv1     <= 1'b0;
      hold0      <= '0;
      hold1      <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      inflight0  <= grant0 & ~req0_wmode;
      inflight1  <= grant1 & ~req1_wmode;
      if (inflight0 & ~resp0_ready) begin
        hold0  <= RW0_rdata;
        holdv0 <= 1'b1;
      end else if (holdv0 & resp0_ready) begin
        holdv0 <= 1'b0;
      end
      if (inflight1 & ~resp1_ready) begin
        hold1  <= RW0_rdata;
        holdv1 <= 1'b1;
      end else if (holdv1 & resp1_ready) begin
        holdv1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_1rw_arb.sv
// Bench for mem_1rw_arb: directed scenarios plus randomized traffic against a
// transaction-level model (memory array, outstanding-read flags, last winner).
module tb_mem_1rw_arb;
  localparam int AW = 5;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req0_wmode, req1_valid, req1_ready, req1_wmode;
  logic [AW-1:0] req0_addr, req1_addr, RW0_addr;
  logic [DW-1:0] req0_wdata, req1_wdata, resp0_rdata, resp1_rdata, RW0_wdata, RW0_rdata;
  logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic          RW0_en, RW0_clk, RW0_wmode;

  always #5 clock = ~clock;

  mem_1rw_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wmode(req0_wmode), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wmode(req1_wmode), .req1_wdata(req1_wdata),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_rdata(resp0_rdata),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_rdata(resp1_rdata),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_clk(RW0_clk), .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  // The 1RW memory the arbiter drives.
  logic [DW-1:0] mem [32];
  always @(posedge RW0_clk) begin
    if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] <= RW0_wdata;
      else           RW0_rdata     <= mem[RW0_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [32];
  logic [1:0]    m_pend;
  logic [DW-1:0] m_exp [2];
  logic          m_last;   // index of the requester granted most recently

  logic          e_g0, e_g1, e_en, e_wmode, e_rv0, e_rv1;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  int errors = 0;
  int checks = 0;

  task automatic predict();
    logic el0, el1;
    el0 = !reset && req0_valid && !m_pend[0];
    el1 = !reset && req1_valid && !m_pend[1];
    if (el0 && el1) begin
      e_g0 = (m_last == 1'b1);
      e_g1 = (m_last == 1'b0);
    end else begin
      e_g0 = el0;
      e_g1 = el1;
    end
    e_en    = e_g0 || e_g1;
    e_addr  = e_g0 ? req0_addr  : (e_g1 ? req1_addr  : '0);
    e_wmode = e_g0 ? req0_wmode : (e_g1 ? req1_wmode : 1'b0);
    e_wdata = e_g0 ? req0_wdata : (e_g1 ? req1_wdata : '0);
    e_rv0   = !reset && m_pend[0];
    e_rv1   = !reset && m_pend[1];
  endtask

  // Advance one clock; the model applies this cycle's transactions at the edge.
  task automatic tick();
    logic g0, g1;
    predict();
    g0 = e_g0;
    g1 = e_g1;
    @(posedge clock);
    if (reset) begin
      m_pend = '0;
      m_last = 1'b1;
    end else begin
      if (m_pend[0] && resp0_ready) m_pend[0] = 1'b0;
      if (m_pend[1] && resp1_ready) m_pend[1] = 1'b0;
      if (g0) begin
        m_last = 1'b0;
        if (req0_wmode) ref_mem[req0_addr] = req0_wdata;
        else begin m_pend[0] = 1'b1; m_exp[0] = ref_mem[req0_addr]; end
      end
      if (g1) begin
        m_last = 1'b1;
        if (req1_wmode) ref_mem[req1_addr] = req1_wdata;
        else begin m_pend[1] = 1'b1; m_exp[1] = ref_mem[req1_addr]; end
      end
    end
    @(negedge clock);
  endtask

  task automatic set_idle();
    req0_valid = 0; req0_wmode = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_wmode = 0; req1_addr = '0; req1_wdata = '0;
    resp0_ready = 1; resp1_ready = 1;
  endtask

  task automatic test_reset();
    reset = 1; req0_valid = 1; req1_valid = 1;
    #1;
    if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end checks++;
    if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end checks++;
    if (RW0_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", RW0_en); end checks++;
    if (resp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rv0: got %b want 0", resp0_valid); end checks++;
    if (resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rv1: got %b want 0", resp1_valid); end checks++;
    tick();
    set_idle();
    tick();
    reset = 0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      req0_addr = AW'($urandom); req0_wdata = {$urandom, $urandom}; req0_wmode = 1'($urandom);
      req1_addr = AW'($urandom); req1_wdata = {$urandom, $urandom}; req1_wmode = 1'($urandom);
      #1;
      if ({RW0_en, RW0_wmode} !== 2'b00) begin errors++; $display("FAIL idle_en_wmode: got %b want 00", {RW0_en, RW0_wmode}); end checks++;
      if (RW0_addr !== '0) begin errors++; $display("FAIL idle_addr: got %h want 0", RW0_addr); end checks++;
      if (RW0_wdata !== '0) begin errors++; $display("FAIL idle_wdata: got %h want 0", RW0_wdata); end checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b want 00", {req0_ready, req1_ready}); end checks++;
      tick();
    end
  endtask

  // Also fills every address, starting from a fresh reset.
  task automatic test_round_robin();
    logic x0, x1;
    set_idle(); reset = 1; tick(); reset = 0;
    for (int i = 0; i < 32; i++) begin
      req0_valid = 1; req0_wmode = 1; req0_addr = AW'(i); req0_wdata = {$urandom, $urandom};
      req1_valid = 1; req1_wmode = 1; req1_addr = AW'(i); req1_wdata = {$urandom, $urandom};
      x0 = (i % 2 == 0);
      x1 = (i % 2 == 1);
      #1;
      if (req0_ready !== x0) begin errors++; $display("FAIL rr_grant0 cyc %0d: got %b want %b", i, req0_ready, x0); end checks++;
      if (req1_ready !== x1) begin errors++; $display("FAIL rr_grant1 cyc %0d: got %b want %b", i, req1_ready, x1); end checks++;
      if (RW0_en !== 1'b1) begin errors++; $display("FAIL rr_en cyc %0d: got %b want 1", i, RW0_en); end checks++;
      tick();
    end
    set_idle();
  endtask

  task automatic test_write_read();
    set_idle();
    req0_valid = 1; req0_wmode = 1; req0_addr = 3; req0_wdata = 64'h1122334455667788;
    #1;
    if ({req0_ready, RW0_en, RW0_wmode} !== 3'b111) begin errors++; $display("FAIL wr_issue: got %b want 111", {req0_ready, RW0_en, RW0_wmode}); end checks++;
    if (RW0_addr !== 5'd3) begin errors++; $display("FAIL wr_addr: got %h want 3", RW0_addr); end checks++;
    if (RW0_wdata !== 64'h1122334455667788) begin errors++; $display("FAIL wr_wdata: got %h want 1122334455667788", RW0_wdata); end checks++;
    tick();
    set_idle();
    req1_valid = 1; req1_wmode = 0; req1_addr = 3;
    #1;
    if ({req1_ready, RW0_en, RW0_wmode} !== 3'b110) begin errors++; $display("FAIL rd_issue: got %b want 110", {req1_ready, RW0_en, RW0_wmode}); end checks++;
    tick();
    set_idle();
    #1;
    if (resp1_valid !== 1'b1) begin errors++; $display("FAIL rd_resp_valid: got %b want 1", resp1_valid); end checks++;
    if (resp1_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL rd_resp_data: got %h want 1122334455667788", resp1_rdata); end checks++;
    tick();
    #1;
    if (resp1_valid !== 1'b0) begin errors++; $display("FAIL rd_resp_done: got %b want 0", resp1_valid); end checks++;
  endtask

  task automatic test_backpressure();
    set_idle();
    req0_valid = 1; req0_wmode = 1; req0_addr = 7; req0_wdata = 64'hA5;
    tick();
    req0_wmode = 0; resp0_ready = 0;
    #1;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_grant: got %b want 1", req0_ready); end checks++;
    tick();
    req1_valid = 1; req1_wmode = 1; req1_addr = 20;
    for (int i = 0; i < 4; i++) begin
      req1_wdata = {$urandom, $urandom};
      resp0_ready = (i == 3);
      #1;
      if (resp0_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d: got %b want 1", i, resp0_valid); end checks++;
      if (resp0_rdata !== 64'hA5) begin errors++; $display("FAIL bp_data cyc %0d: got %h want a5", i, resp0_rdata); end checks++;
      if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready0 cyc %0d: got %b want 0", i, req0_ready); end checks++;
      if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 cyc %0d: got %b want 1", i, req1_ready); end checks++;
      tick();
    end
    set_idle();
    #1;
    if (resp0_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", resp0_valid); end checks++;
  endtask

  task automatic test_hazard();
    set_idle();
    req1_valid = 1; req1_wmode = 1; req1_addr = 5; req1_wdata = 64'h01;
    tick();
    req0_valid = 1; req0_wmode = 0; req0_addr = 5;
    req1_wdata = 64'hFF;
    #1;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL hz_order: got %b want 10", {req0_ready, req1_ready}); end checks++;
    tick();
    req0_valid = 0;
    #1;
    if (resp0_valid !== 1'b1) begin errors++; $display("FAIL hz_valid: got %b want 1", resp0_valid); end checks++;
    if (resp0_rdata !== 64'h01) begin errors++; $display("FAIL hz_old_data: got %h want 01", resp0_rdata); end checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL hz_write_next: got %b want 1", req1_ready); end checks++;
    tick();
    set_idle();
    req0_valid = 1; req0_wmode = 0; req0_addr = 5;
    tick();
    set_idle();
    #1;
    if (resp0_rdata !== 64'hFF) begin errors++; $display("FAIL hz_new_data: got %h want ff", resp0_rdata); end checks++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    set_idle();
    req0_valid = 1; req0_wmode = 0; req0_addr = 3;
    #1;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL rmr_grant: got %b want 1", req0_ready); end checks++;
    tick();
    set_idle(); resp0_ready = 0; reset = 1;
    #1;
    if (resp0_valid !== 1'b0) begin errors++; $display("FAIL rmr_during: got %b want 0", resp0_valid); end checks++;
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (resp0_valid !== 1'b0) begin errors++; $display("FAIL rmr_after cyc %0d: got %b want 0", i, resp0_valid); end checks++;
      tick();
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 79) == 0);
      req0_valid  = 1'($urandom); req0_wmode = 1'($urandom); req0_addr = AW'($urandom_range(0, 7));
      req0_wdata  = {$urandom, $urandom};
      req1_valid  = 1'($urandom); req1_wmode = 1'($urandom); req1_addr = AW'($urandom_range(0, 7));
      req1_wdata  = {$urandom, $urandom};
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      #1;
      predict();
      if (req0_ready !== e_g0) begin errors++; $display("FAIL rnd_ready0 cyc %0d: got %b want %b", i, req0_ready, e_g0); end checks++;
      if (req1_ready !== e_g1) begin errors++; $display("FAIL rnd_ready1 cyc %0d: got %b want %b", i, req1_ready, e_g1); end checks++;
      if (RW0_en !== e_en) begin errors++; $display("FAIL rnd_en cyc %0d: got %b want %b", i, RW0_en, e_en); end checks++;
      if (RW0_addr !== e_addr) begin errors++; $display("FAIL rnd_addr cyc %0d: got %h want %h", i, RW0_addr, e_addr); end checks++;
      if (RW0_wmode !== e_wmode) begin errors++; $display("FAIL rnd_wmode cyc %0d: got %b want %b", i, RW0_wmode, e_wmode); end checks++;
      if (RW0_wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata cyc %0d: got %h want %h", i, RW0_wdata, e_wdata); end checks++;
      if (resp0_valid !== e_rv0) begin errors++; $display("FAIL rnd_rv0 cyc %0d: got %b want %b", i, resp0_valid, e_rv0); end checks++;
      if (resp1_valid !== e_rv1) begin errors++; $display("FAIL rnd_rv1 cyc %0d: got %b want %b", i, resp1_valid, e_rv1); end checks++;
      if (e_rv0) begin
        if (resp0_rdata !== m_exp[0]) begin errors++; $display("FAIL rnd_rdata0 cyc %0d: got %h want %h", i, resp0_rdata, m_exp[0]); end checks++;
      end
      if (e_rv1) begin
        if (resp1_rdata !== m_exp[1]) begin errors++; $display("FAIL rnd_rdata1 cyc %0d: got %h want %h", i, resp1_rdata, m_exp[1]); end checks++;
      end
      tick();
    end
    reset = 0;
    set_idle();
  endtask

  initial begin
    m_pend = '0;
    m_last = 1'b1;
    reset  = 1;
    set_idle();
    @(negedge clock);
    test_reset();
    test_idle();
    test_round_robin();
    test_write_read();
    test_backpressure();
    test_hazard();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
